mux_n_rr: RTL and testbench

- N-channel, WIDTH-bit arbitrated multiplexer with valid/ready handshake on every input and on the output. It is the parametrised successor to the fixed 2:1 16-bit mux.
- Selection is made by an internal arbiter rather than an external select line. The arbiter runs in either round-robin or fixed-priority mode.
- Output is registered in a one-entry skid-free holding stage, so results appear one cycle after acceptance.
- Sits between multiple producers (e.g. ALU, memory read path) and a single shared consumer bus.

---
 rtl/mux_n_rr_pkg.sv | 26 ++
 rtl/mux_n_rr_if.sv | 28 ++
 rtl/mux_n_rr_rr_pick.sv | 35 +++
 rtl/mux_n_rr.sv | 76 +++++++
 tb/tb_mux_n_rr.sv | 134 +++++++++++++
 5 files changed

// File: rtl/mux_n_rr_pkg.sv
// Shared definitions for the arbitrated N:1 mux family: default sizes,
// arbitration mode encoding and an elaboration-time log2 helper.
package mux_n_rr_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_N     = 4;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } arb_mode_e;

  // Ceiling log2, usable in parameter expressions; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mux_n_rr_if.sv
// Handshake bundle between N producers, the arbitrated mux and one consumer.
interface mux_n_rr_if #(
  parameter int WIDTH = mux_n_rr_pkg::DEF_WIDTH,
  parameter int N     = mux_n_rr_pkg::DEF_N
);

  localparam int SEL_W = mux_n_rr_pkg::clog2(N);

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic               out_ready;

  // Master is the environment (producers plus consumer); slave is the mux.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/mux_n_rr_rr_pick.sv
// Combinational requester picker: round-robin from a pointer or fixed
// lowest-index priority, producing a one-hot grant and its encoded index.
module rr_pick
  import mux_n_rr_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0]                req,
  input  logic [clog2(N)-1:0]         ptr,
  input  arb_mode_e                   mode,
  output logic [N-1:0]                grant,
  output logic [clog2(N)-1:0]         idx,
  output logic                        any
);

  localparam int SEL_W = clog2(N);

  // Walk the channels in search order; the first requester found wins.
  always_comb begin : pick
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (mode == MODE_FIXED) ? k : (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        grant[j] = 1'b1;
        idx      = SEL_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_n_rr.sv
// N-channel arbitrated multiplexer with a one-entry registered output stage
// and valid/ready handshakes on every input and on the output.
module mux_n_rr
  import mux_n_rr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  mux_n_rr_if.slave  bus
);

  localparam int SEL_W = clog2(N);

  logic [N-1:0]            grant;
  logic [SEL_W-1:0]        grant_idx;
  logic                    any_req;
  logic [SEL_W-1:0]        rr_ptr;
  logic                    load_en;
  logic                    transfer;
  logic [N-1:0][WIDTH-1:0] masked;
  logic [WIDTH-1:0]        sel_data;
  logic                    valid_q;
  logic [WIDTH-1:0]        data_q;
  logic [SEL_W-1:0]        sel_q;

  rr_pick #(.N(N)) u_pick (
    .req   (bus.in_valid),
    .ptr   (rr_ptr),
    .mode  (arb_mode_e'(mode)),
    .grant (grant),
    .idx   (grant_idx),
    .any   (any_req)
  );

  // Nothing is accepted while reset is held, since it would be discarded.
  assign load_en      = rst_n && (!valid_q || bus.out_ready);
  assign transfer     = load_en && any_req;
  assign bus.in_ready = {N{load_en}} & grant;

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign masked[i] = {WIDTH{grant[i]}} & bus.in_data[i*WIDTH +: WIDTH];
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      sel_data = sel_data | masked[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      rr_ptr  <= '0;
    end else if (transfer) begin
      valid_q <= 1'b1;
      data_q  <= sel_data;
      sel_q   <= grant_idx;
      if (arb_mode_e'(mode) == MODE_RR) begin
        rr_ptr <= (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + SEL_W'(1);
      end
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_mux_n_rr.sv
// Directed self-checking bench for mux_n_rr with N=4, WIDTH=16 and channel
// i driving 16'hA000+i.
module tb_mux_n_rr;

  localparam int WIDTH = 16;
  localparam int N     = 4;

  logic clk;
  logic rst_n;
  logic mode;
  int   tests_run;
  int   tests_failed;

  mux_n_rr_if #(.WIDTH(WIDTH), .N(N)) bus ();

  mux_n_rr #(.WIDTH(WIDTH), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic ready, input logic md);
    bus.in_valid  = valid;
    bus.out_ready = ready;
    mode          = md;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOut(input string tag, input logic v, input logic [15:0] d, input logic [1:0] s);
    checkOutput({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    checkOutput({tag, ".data"},  32'(bus.out_data),  32'(d));
    checkOutput({tag, ".sel"},   32'(bus.out_sel),   32'(s));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < N; i++) begin
      bus.in_data[i*WIDTH +: WIDTH] = 16'hA000 + 16'(i);
    end
    rst_n = 1'b0;
    applyStimulus(4'b1111, 1'b1, 1'b0);
    #2;

    // Reset state with every channel requesting
    checkOut("reset", 1'b0, 16'h0000, 2'd0);
    checkOutput("reset.in_ready", 32'(bus.in_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rel.in_ready", 32'(bus.in_ready), 32'b0001);
    tick();
    checkOut("rel", 1'b1, 16'hA000, 2'd0);

    // Round-robin rotation with continuous drain and reload
    tick(); checkOut("rr1", 1'b1, 16'hA001, 2'd1);
    tick(); checkOut("rr2", 1'b1, 16'hA002, 2'd2);
    tick(); checkOut("rr3", 1'b1, 16'hA003, 2'd3);
    tick(); checkOut("rr4", 1'b1, 16'hA000, 2'd0);
    tick(); checkOut("rr5", 1'b1, 16'hA001, 2'd1);
    tick(); checkOut("rr6", 1'b1, 16'hA002, 2'd2);

    // Backpressure while holding A002
    applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("bp.in_ready0", 32'(bus.in_ready), 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOut("bp.hold", 1'b1, 16'hA002, 2'd2);
      checkOutput("bp.in_ready", 32'(bus.in_ready), 32'h0);
    end
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("bp.release_ready", 32'(bus.in_ready), 32'b1000);
    tick(); checkOut("bp.next", 1'b1, 16'hA003, 2'd3);

    // Fixed priority with channel 0 silent
    applyStimulus(4'b1110, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      checkOutput("fp.in_ready", 32'(bus.in_ready), 32'b0010);
      tick();
      checkOut("fp", 1'b1, 16'hA001, 2'd1);
    end

    // Sparse requests and pointer wrap in round-robin mode
    applyStimulus(4'b0100, 1'b1, 1'b0);
    tick(); checkOut("sp.ch2", 1'b1, 16'hA002, 2'd2);
    applyStimulus(4'b0010, 1'b1, 1'b0);
    checkOutput("sp.single_ready", 32'(bus.in_ready), 32'b0010);
    tick(); checkOut("sp.ch1", 1'b1, 16'hA001, 2'd1);
    applyStimulus(4'b1001, 1'b1, 1'b0);
    checkOutput("sp.ptr2_ready", 32'(bus.in_ready), 32'b1000);
    tick(); checkOut("sp.ch3", 1'b1, 16'hA003, 2'd3);
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("wrap.ready", 32'(bus.in_ready), 32'b0001);
    tick(); checkOut("wrap", 1'b1, 16'hA000, 2'd0);

    // Drain without refill
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("drain.in_ready", 32'(bus.in_ready), 32'h0);
    tick(); checkOut("drain", 1'b0, 16'hA000, 2'd0);

    // Asynchronous reset while a word is held
    applyStimulus(4'b0010, 1'b1, 1'b0);
    tick(); checkOut("pre_rst", 1'b1, 16'hA001, 2'd1);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOut("async_rst", 1'b0, 16'h0000, 2'd0);
    rst_n = 1'b1;
    tick(); checkOutput("post_rst.valid", 32'(bus.out_valid), 32'h0);
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("post_rst.ptr", 32'(bus.in_ready), 32'b0001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
